// File: rtl/test_monitor_if.sv
// test_monitor_if: end-of-test monitor bus (channel end strobes/codes in, verdict and diagnostics out)
// Ports (signals): i_end_flag, i_end_data, i_heartbeat driven by the SoC side (master);
//   o_core_rst_n, o_done, o_pass, o_fail, o_timeout, o_end_mask, o_fail_mask,
//   o_first_fail, o_cycles driven by the monitor (slave).
interface test_monitor_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH = 4
);
  localparam int FW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] i_end_flag;
  logic [NUM_CH*DATA_WIDTH-1:0] i_end_data;
  logic i_heartbeat;
  logic o_core_rst_n;
  logic o_done;
  logic o_pass;
  logic o_fail;
  logic o_timeout;
  logic [NUM_CH-1:0] o_end_mask;
  logic [NUM_CH-1:0] o_fail_mask;
  logic [FW-1:0] o_first_fail;
  logic [31:0] o_cycles;
  modport master (
    output i_end_flag, i_end_data, i_heartbeat,
    input o_core_rst_n, o_done, o_pass, o_fail, o_timeout,
    input o_end_mask, o_fail_mask, o_first_fail, o_cycles
  );
  modport slave (
    input i_end_flag, i_end_data, i_heartbeat,
    output o_core_rst_n, o_done, o_pass, o_fail, o_timeout,
    output o_end_mask, o_fail_mask, o_first_fail, o_cycles
  );
endinterface

// File: rtl/test_monitor.sv
// test_monitor: multi-channel end-of-test monitor with core reset sequencing and watchdog
// Ports: i_sys_clk, i_sys_rst (async, active-high); bus (test_monitor_if.slave) carries
//   per-channel end strobes/codes, heartbeat, and the sticky verdict plus diagnostics.
// Optional: define TEST_MON_HEARTBEAT_EN to make the watchdog count cycles since the
//   last i_heartbeat instead of absolute RUN cycles.
module test_monitor #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH = 4,
  parameter logic [DATA_WIDTH-1:0] PASS_CODE = '0,
  parameter int RST_HOLD = 4,
  parameter int TIMEOUT = 100000
) (
  input logic i_sys_clk,
  input logic i_sys_rst,
  test_monitor_if.slave bus
);
  localparam int FW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] HOLD = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [31:0] hold_cnt;
  logic [31:0] cycles;
  logic core_rst_n, done, pass, fail, timeout, wd_exp;
  logic [NUM_CH-1:0] end_mask, fail_mask, new_end, new_fail, end_nx, fail_nx;
  logic [FW-1:0] first_fail, ff_idx;
  // descending scan so the lowest failing index of the cycle wins
  always_comb begin
    new_end = bus.i_end_flag & ~end_mask;
    new_fail = '0;
    ff_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (new_end[k] && bus.i_end_data[k*DATA_WIDTH +: DATA_WIDTH] != PASS_CODE) begin
        new_fail[k] = 1'b1;
        ff_idx = FW'(k);
      end
    end_nx = end_mask | new_end;
    fail_nx = fail_mask | new_fail;
  end
`ifdef TEST_MON_HEARTBEAT_EN
  logic [31:0] wd;
  // a heartbeat on the expiry cycle rescues the run
  assign wd_exp = wd == 32'(TIMEOUT - 1) && !bus.i_heartbeat;
  always_ff @(posedge i_sys_clk or posedge i_sys_rst)
    if (i_sys_rst) wd <= '0;
    else if (state == RUN) wd <= bus.i_heartbeat ? '0 : wd + 32'd1;
`else
  logic unused_hb;
  assign unused_hb = bus.i_heartbeat;
  assign wd_exp = cycles == 32'(TIMEOUT - 1);
`endif
  always_ff @(posedge i_sys_clk or posedge i_sys_rst)
    if (i_sys_rst) begin
      state <= HOLD;
      hold_cnt <= '0;
      cycles <= '0;
      core_rst_n <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      timeout <= 1'b0;
      end_mask <= '0;
      fail_mask <= '0;
      first_fail <= '0;
    end else if (state == HOLD) begin
      if (hold_cnt == 32'(RST_HOLD - 1)) begin
        state <= RUN;
        core_rst_n <= 1'b1;
      end else hold_cnt <= hold_cnt + 32'd1;
    end else if (state == RUN) begin
      cycles <= &cycles ? cycles : cycles + 32'd1;
      end_mask <= end_nx;
      fail_mask <= fail_nx;
      if (|new_fail) first_fail <= ff_idx;
      if (|fail_nx) begin
        fail <= 1'b1;
        done <= 1'b1;
        state <= DONE;
      end else if (&end_nx) begin
        pass <= 1'b1;
        done <= 1'b1;
        state <= DONE;
      end else if (wd_exp) begin
        timeout <= 1'b1;
        done <= 1'b1;
        state <= DONE;
      end
    end
  assign bus.o_core_rst_n = core_rst_n;
  assign bus.o_done = done;
  assign bus.o_pass = pass;
  assign bus.o_fail = fail;
  assign bus.o_timeout = timeout;
  assign bus.o_end_mask = end_mask;
  assign bus.o_fail_mask = fail_mask;
  assign bus.o_first_fail = first_fail;
  assign bus.o_cycles = cycles;
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed bench for test_monitor (NUM_CH=4, RST_HOLD=4, TIMEOUT=50)
module tb_test_monitor;
  logic i_sys_clk = 1'b0;
  logic i_sys_rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  test_monitor_if #(.DATA_WIDTH(32), .NUM_CH(4)) bus ();
  test_monitor #(
    .DATA_WIDTH(32), .NUM_CH(4), .PASS_CODE(32'h0), .RST_HOLD(4), .TIMEOUT(50)
  ) dut (
    .i_sys_clk(i_sys_clk),
    .i_sys_rst(i_sys_rst),
    .bus(bus)
  );
  always #5 i_sys_clk = ~i_sys_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge i_sys_clk);
    #1;
  endtask
  task automatic flag(input logic [3:0] f, input logic [127:0] d);
    bus.i_end_flag = f;
    bus.i_end_data = d;
    tick(1);
    bus.i_end_flag = '0;
    bus.i_end_data = '0;
  endtask
  task automatic reset_now(input string tag);
    i_sys_rst = 1'b1;
    #2;
    check({tag, "_rst_core"}, 32'(bus.o_core_rst_n), 0);
    check({tag, "_rst_done"}, 32'(bus.o_done), 0);
    check({tag, "_rst_cyc"}, bus.o_cycles, 0);
    check({tag, "_rst_end"}, 32'(bus.o_end_mask), 0);
  endtask
  task automatic release_rst(input string tag);
    @(negedge i_sys_clk);
    i_sys_rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      check({tag, "_hold_core"}, 32'(bus.o_core_rst_n), 0);
      check({tag, "_hold_cyc"}, bus.o_cycles, 0);
    end
    tick(1);
    check({tag, "_core_up"}, 32'(bus.o_core_rst_n), 1);
    check({tag, "_run_done"}, 32'(bus.o_done), 0);
  endtask
  initial begin
    bus.i_end_flag = '0;
    bus.i_end_data = '0;
    bus.i_heartbeat = 1'b0;
    tick(2);
    reset_now("init");
    check("init_status", 32'({bus.o_pass, bus.o_fail, bus.o_timeout}), 0);
    release_rst("init");
    // all pass: ends at cycles 10, 12, 12, 30
    tick(10);
    flag(4'b0001, '0);
    check("ap_end1", 32'(bus.o_end_mask), 32'h1);
    tick(1);
    flag(4'b0110, '0);
    check("ap_end2", 32'(bus.o_end_mask), 32'h7);
    check("ap_notdone", 32'(bus.o_done), 0);
    tick(17);
    flag(4'b1000, '0);
    check("ap_pass", 32'({bus.o_done, bus.o_pass, bus.o_fail, bus.o_timeout}), 32'b1100);
    check("ap_end_all", 32'(bus.o_end_mask), 32'hF);
    check("ap_cycles", bus.o_cycles, 31);
    tick(5);
    check("ap_frozen", bus.o_cycles, 31);
    // early fail: ch0 pass + ch2 fail at cycle 5
    reset_now("ef");
    release_rst("ef");
    tick(5);
    flag(4'b0101, {32'h0, 32'h1, 32'h0, 32'h0});
    check("ef_verdict", 32'({bus.o_done, bus.o_pass, bus.o_fail, bus.o_timeout}), 32'b1010);
    check("ef_fmask", 32'(bus.o_fail_mask), 32'b0100);
    check("ef_first", 32'(bus.o_first_fail), 2);
    check("ef_end", 32'(bus.o_end_mask), 32'b0101);
    flag(4'b0010, '0);
    check("ef_late_end", 32'(bus.o_end_mask), 32'b0101);
    check("ef_cyc", bus.o_cycles, 6);
    // fail beats pass when the last channel fails; lowest failing index wins
    reset_now("pr");
    release_rst("pr");
    tick(2);
    flag(4'b0001, '0);
    flag(4'b1110, {32'h9, 32'h0, 32'h5, 32'h0});
    check("pr_verdict", 32'({bus.o_done, bus.o_pass, bus.o_fail, bus.o_timeout}), 32'b1010);
    check("pr_fmask", 32'(bus.o_fail_mask), 32'b1010);
    check("pr_first", 32'(bus.o_first_fail), 1);
    check("pr_end", 32'(bus.o_end_mask), 32'hF);
    // absolute timeout with no flags
    reset_now("to");
    release_rst("to");
    tick(49);
    check("to_before", 32'({bus.o_done, bus.o_timeout}), 0);
    check("to_cyc49", bus.o_cycles, 49);
    tick(1);
    check("to_verdict", 32'({bus.o_done, bus.o_pass, bus.o_fail, bus.o_timeout}), 32'b1001);
    check("to_cyc", bus.o_cycles, 50);
    flag(4'hF, '0);
    tick(2);
    check("to_frozen_v", 32'({bus.o_pass, bus.o_fail, bus.o_timeout}), 32'b001);
    check("to_frozen_end", 32'(bus.o_end_mask), 0);
    check("to_frozen_cyc", bus.o_cycles, 50);
`ifdef TEST_MON_HEARTBEAT_EN
    reset_now("hb");
    release_rst("hb");
    for (int i = 0; i < 200; i++) begin
      bus.i_heartbeat = (i % 40 == 39);
      tick(1);
    end
    bus.i_heartbeat = 1'b0;
    check("hb_alive", 32'({bus.o_done, bus.o_timeout}), 0);
    check("hb_cyc", bus.o_cycles, 200);
    tick(49);
    check("hb_pre", 32'(bus.o_timeout), 0);
    tick(1);
    check("hb_timeout", 32'({bus.o_done, bus.o_timeout}), 32'b11);
    check("hb_cyc_end", bus.o_cycles, 250);
`endif
    // reset mid-run with two channels captured
    reset_now("mr");
    release_rst("mr");
    tick(5);
    flag(4'b0011, '0);
    tick(14);
    check("mr_cyc20", bus.o_cycles, 20);
    check("mr_end", 32'(bus.o_end_mask), 32'b0011);
    reset_now("mr2");
    release_rst("mr2");
    check("mr_end_clr", 32'(bus.o_end_mask), 0);
    check("mr_fail_clr", 32'(bus.o_fail_mask), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
